// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns engine: one 128-bit state per
// valid/ready handshake, COLS_PER_CYCLE columns transformed per clock.
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inverse,
    input  logic [0:127] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] state_out
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r;
    logic [1:0]     col_idx_r;
    logic           mode_r;
    logic           in_ready_r;
    logic           out_valid_r;
    logic [127:0]   work_r;
    logic [127:0]   next_work_s;
    logic           last_s;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Coefficients up to 0x0e decompose into x, 2x, 4x and 8x terms.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? x  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    // Each matrix row is the base row rotated right by the row number.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0]  a [4];
        logic [3:0]  base [4];
        logic [7:0]  b;
        logic [31:0] res;
        res = 32'h0;
        for (int k = 0; k < 4; k++) begin
            a[k] = col[31 - 8*k -: 8];
        end
        if (inv) begin
            base[0] = 4'he; base[1] = 4'hb; base[2] = 4'hd; base[3] = 4'h9;
        end else begin
            base[0] = 4'h2; base[1] = 4'h3; base[2] = 4'h1; base[3] = 4'h1;
        end
        for (int r = 0; r < 4; r++) begin
            b = 8'h00;
            for (int k = 0; k < 4; k++) begin
                b = b ^ gf_mul(a[k], base[2'(k - r)]);
            end
            res[31 - 8*r -: 8] = b;
        end
        return res;
    endfunction

    // Transform the columns selected by col_idx_r; others pass through.
    always_comb begin
        next_work_s = work_r;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            next_work_s[127 - 32*int'(col_idx_r + 2'(j)) -: 32] =
                mix_col(work_r[127 - 32*int'(col_idx_r + 2'(j)) -: 32], mode_r);
        end
    end

    assign last_s = (col_idx_r == 2'(4 - COLS_PER_CYCLE));

    // Control FSM with registered handshake outputs and the working state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            col_idx_r   <= 2'd0;
            mode_r      <= 1'b0;
            work_r      <= 128'h0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        work_r     <= state_in;
                        mode_r     <= inverse;
                        col_idx_r  <= 2'd0;
                        in_ready_r <= 1'b0;
                        state_r    <= BUSY;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                BUSY: begin
                    work_r    <= next_work_s;
                    col_idx_r <= col_idx_r + 2'(COLS_PER_CYCLE);
                    if (last_s) begin
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    col_idx_r   <= 2'd0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign state_out = work_r;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: three instances (1, 2 and 4 columns per cycle)
// checked against known vectors and a polynomial-arithmetic reference model.
module tb_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid_a  [3];
    logic         in_ready_a  [3];
    logic         inverse_a   [3];
    logic [127:0] state_in_a  [3];
    logic         out_valid_a [3];
    logic         out_ready_a [3];
    logic [127:0] state_out_a [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid_a[g]),
                .in_ready  (in_ready_a[g]),
                .inverse   (inverse_a[g]),
                .state_in  (state_in_a[g]),
                .out_valid (out_valid_a[g]),
                .out_ready (out_ready_a[g]),
                .state_out (state_out_a[g])
            );
        end
    endgenerate

    typedef struct {
        logic [127:0] din;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [3];

    // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   fwd [4];
        logic [7:0]   invc [4];
        logic [7:0]   a [4];
        logic [7:0]   acc;
        logic [127:0] r;
        fwd  = '{8'h02, 8'h03, 8'h01, 8'h01};
        invc = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 8*(4*c + k) -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(a[k], inv ? invc[(k - row + 4) % 4] : fwd[(k - row + 4) % 4]);
                r[127 - 8*(4*c + row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one block with out_ready high; optionally scramble inputs while busy.
    task automatic run_block(input int d, input logic [127:0] s, input logic inv, input bit flip,
                             output logic [127:0] res, output int lat);
        state_in_a[d]  = s;
        inverse_a[d]   = inv;
        in_valid_a[d]  = 1'b1;
        out_ready_a[d] = 1'b1;
        tick();
        in_valid_a[d] = 1'b0;
        if (flip) begin
            inverse_a[d]  = ~inv;
            state_in_a[d] = ~s;
        end
        lat = 0;
        while (!out_valid_a[d] && lat < 20) begin
            tick();
            lat++;
        end
        res = state_out_a[d];
        tick();
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] s;
        logic [127:0] snap;
        int           lat;
        int           n;
        int           errs;
        int           xfers;
        int           last_acc;
        logic         inv;

        tbl[0] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c};
        tbl[1] = '{128'hdb135345f20a225c01010101d4d4d4d5, 1'b0, 128'h8e4da1bc9fdc589d01010101d5d5d7d6};
        tbl[2] = '{128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5};

        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid_a[d]  = 1'b0;
            inverse_a[d]   = 1'b0;
            state_in_a[d]  = 128'h0;
            out_ready_a[d] = 1'b0;
        end
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_in_ready[%0d]", d), 128'(in_ready_a[d]), 128'h1);
            chk($sformatf("reset_out_valid[%0d]", d), 128'(out_valid_a[d]), 128'h0);
            chk($sformatf("reset_state_out[%0d]", d), state_out_a[d], 128'h0);
        end
        rst = 1'b0;
        tick();

        // Known vectors, latency, and inputs scrambled while busy.
        for (int d = 0; d < 3; d++) begin
            n = 4 >> d;
            for (int i = 0; i < 3; i++) begin
                run_block(d, tbl[i].din, tbl[i].inv, (i == 2), res, lat);
                chk($sformatf("vec%0d_data[%0d]", i, d), res, tbl[i].exp);
                chk($sformatf("vec%0d_latency[%0d]", i, d), 128'(lat), 128'(n));
            end
        end

        // Random blocks against the reference model.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 20; i++) begin
                s   = {$urandom, $urandom, $urandom, $urandom};
                inv = 1'($urandom_range(0, 1));
                run_block(d, s, inv, bit'(i & 1), res, lat);
                chk($sformatf("rand%0d_data[%0d]", i, d), res, ref_mix(s, inv));
            end
        end

        // Back-pressure: DONE held for 10 cycles, then exactly one transfer.
        for (int d = 0; d < 3; d += 2) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            state_in_a[d]  = s;
            inverse_a[d]   = 1'b0;
            in_valid_a[d]  = 1'b1;
            out_ready_a[d] = 1'b0;
            tick();
            in_valid_a[d] = 1'b0;
            lat = 0;
            while (!out_valid_a[d] && lat < 20) begin
                tick();
                lat++;
            end
            chk($sformatf("bp_latency[%0d]", d), 128'(lat), 128'(4 >> d));
            snap = state_out_a[d];
            chk($sformatf("bp_data[%0d]", d), snap, ref_mix(s, 1'b0));
            errs = 0;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (state_out_a[d] !== snap || in_ready_a[d] !== 1'b0 || out_valid_a[d] !== 1'b1) errs++;
            end
            chk($sformatf("bp_hold_errors[%0d]", d), 128'(errs), 128'h0);
            out_ready_a[d] = 1'b1;
            xfers = 0;
            for (int c = 0; c < 6; c++) begin
                if (out_valid_a[d] && out_ready_a[d]) xfers++;
                tick();
            end
            chk($sformatf("bp_transfers[%0d]", d), 128'(xfers), 128'h1);
            chk($sformatf("bp_in_ready_after[%0d]", d), 128'(in_ready_a[d]), 128'h1);
        end

        // Back-to-back: accepts spaced exactly N+2 cycles apart.
        for (int d = 0; d < 3; d++) begin
            n = 4 >> d;
            in_valid_a[d]  = 1'b1;
            out_ready_a[d] = 1'b1;
            last_acc = -1;
            errs = 0;
            xfers = 0;
            for (int c = 0; c < 4 * (n + 2); c++) begin
                state_in_a[d] = {$urandom, $urandom, $urandom, $urandom};
                if (in_valid_a[d] && in_ready_a[d]) begin
                    if (last_acc >= 0 && (c - last_acc) != n + 2) errs++;
                    last_acc = c;
                    xfers++;
                end
                tick();
            end
            in_valid_a[d] = 1'b0;
            chk($sformatf("b2b_period_errors[%0d]", d), 128'(errs), 128'h0);
            chk($sformatf("b2b_accepts[%0d]", d), 128'(xfers), 128'h4);
            lat = 0;
            while (!in_ready_a[d] && lat < 20) begin
                tick();
                lat++;
            end
        end

        // Reset in the middle of a block (one column per cycle, after 2 compute edges).
        state_in_a[0]  = tbl[0].din;
        inverse_a[0]   = 1'b0;
        in_valid_a[0]  = 1'b1;
        out_ready_a[0] = 1'b1;
        tick();
        in_valid_a[0] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", 128'(in_ready_a[0]), 128'h1);
        chk("midrst_out_valid", 128'(out_valid_a[0]), 128'h0);
        chk("midrst_state_out", state_out_a[0], 128'h0);
        errs = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid_a[0] !== 1'b0) errs++;
        end
        chk("midrst_stale_output", 128'(errs), 128'h0);
        run_block(0, tbl[2].din, 1'b1, 1'b0, res, lat);
        chk("midrst_next_block", res, tbl[2].exp);

        // Reset together with in_valid in IDLE: no acceptance.
        state_in_a[1] = tbl[0].din;
        in_valid_a[1] = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid_a[1] = 1'b0;
        chk("rst_vs_valid_in_ready", 128'(in_ready_a[1]), 128'h1);
        errs = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (out_valid_a[1] !== 1'b0 || in_ready_a[1] !== 1'b1) errs++;
        end
        chk("rst_vs_valid_no_block", 128'(errs), 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mix_columns_iter.md
# mix_columns_iter

Iterative AES MixColumns / InvMixColumns unit for the round datapath. It accepts one 128-bit state through a valid/ready handshake and processes COLS_PER_CYCLE columns per clock with correct GF(2^8) arithmetic. It selects the forward or inverse matrix per block and holds the result until the downstream stage accepts it. It sits between ShiftRows (InvShiftRows) and AddRoundKey, and trades area against latency through a single parameter.

## Interface
- COLS_PER_CYCLE, 1: columns computed per cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  state_in and inverse are valid.
- in_ready  output  1  block can accept a new state.
- inverse  input  1  0 = MixColumns, 1 = InvMixColumns; sampled at acceptance.
- state_in  input  [0:127]  input state. Byte k is bits [8k:8k+7], MSB first. Column c is bytes 4c..4c+3, with byte 4c as row 0.
- out_valid  output  1  state_out holds a finished result.
- out_ready  input  1  downstream accepts the result.
- state_out  output  [0:127]  result, same byte/column layout as state_in.

## Operation
- N = 4 / COLS_PER_CYCLE, the number of compute cycles per block.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid & in_ready on an edge: capture state_in into the working register, capture inverse into mode_q, clear col_idx to 0, go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each edge replaces columns col_idx .. col_idx+COLS_PER_CYCLE-1 of the working register with their transform, then col_idx += COLS_PER_CYCLE.
  - After the edge that processes column 3, go to DONE. col_idx is 2 bits and wraps to 0.
- DONE:
  - out_valid = 1 and state_out = working register, held stable until out_valid & out_ready.
  - On that edge go to IDLE.
  - in_ready stays 0 in DONE; there is no overlap of accept and output.
- Forward transform, column (a0..a3):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- Inverse transform uses the coefficient rows {0e,0b,0d,09}, {09,0e,0b,0d}, {0d,09,0e,0b}, {0b,0d,09,0e}.
- GF(2^8) arithmetic:
  - xtime(x) = (x<<1) ^ (x[7] ? 8'h1B : 0), truncated to 8 bits.
  - 3x = xtime(x)^x; other coefficients are built from repeated xtime and XOR.
  - Integer multiplication is forbidden.
- state_in and inverse are don't-care outside the accept edge. Changes during BUSY or DONE have no effect.
- state_out is undefined-stable (holds its last value) while out_valid = 0. Benches check it only when out_valid = 1.
- Reset at any edge with rst = 1 overrides all activity:
  - FSM goes to IDLE, col_idx = 0, mode_q = 0, working register = 0.
  - An in-flight block is discarded with no output.
- Reset values (visible after the reset edge): in_ready = 1, out_valid = 0, state_out = 128'h0.

## Timing
- Accept on edge k: out_valid rises after edge k+N, i.e. latency N cycles (4, 2 or 1).
- If out_ready is held high, the output handshake occurs on edge k+N+1 and in_ready returns after that edge.
- Next accept is on edge k+N+2, so peak throughput is one block per N+2 cycles.
- Back-pressure: out_ready low holds DONE indefinitely with state_out and out_valid unchanged.
- in_ready and out_valid are decoded from FSM state only. There is no combinational path from in_valid or out_ready to any output.
- rst asserted together with in_valid in IDLE: no acceptance; reset wins.

## Test plan
- Forward, full block, for each COLS_PER_CYCLE (1/2/4):
  - Stimulus: state_in = d4bf5d30e0b452aeb84111f11e2798e5, inverse = 0.
  - Required: state_out = 046681e5e0cb199a48f8d37a2806264c, out_valid exactly 4/2/1 cycles after accept.
- Column vectors, forward:
  - Stimulus: columns db135345 | f20a225c | 01010101 | d4d4d4d5.
  - Required: 8e4da1bc | 9fdc589d | 01010101 | d5d5d7d6. This exercises the 0x1B reduction.
- Inverse:
  - Stimulus: state_in = 046681e5e0cb199a48f8d37a2806264c, inverse = 1.
  - Required: d4bf5d30e0b452aeb84111f11e2798e5.
  - Also toggle inverse during BUSY and confirm no effect on the result.
- Back-pressure and handshake:
  - Stimulus: hold out_ready = 0 for 10 cycles in DONE.
  - Required: state_out stable, in_ready = 0 throughout.
  - Then raise out_ready and confirm exactly one transfer.
  - Back-to-back in_valid must achieve a period of N+2.
- Reset mid-operation:
  - Stimulus: assert rst during BUSY (COLS_PER_CYCLE = 1, after 2 compute cycles).
  - Required: next cycle in_ready = 1, out_valid = 0, state_out = 0, and no stale output appears.
  - A new block then completes correctly.
